sram_uart_dump_tx: RTL

// Reads a contiguous region of the external SRAM word by word and transmits it over UART, 8N1.
// For each 16-bit word it sends the high byte first, then the low byte.

---
 rtl/sram_uart_dump_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sram_uart_dump_tx.sv
// sram_uart_dump_tx: streams a contiguous SRAM region out of UART_TX_O (8N1).
// Each 16-bit word goes out as two bytes, high byte first, with no idle time
// between the two bytes. There are 2 + SRAM_READ_LATENCY idle-high cycles
// between words.
// Handshake: Start_I is a one-cycle request that is honoured only in S_IDLE.
// Busy_O is high while the transfer runs. Done_O pulses for one cycle when the
// transfer completes, and the block is back in S_IDLE on the next cycle.
module sram_uart_dump_tx #(
  parameter int CLKS_PER_BIT      = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start_I,
  input  logic [17:0] Base_address_I,
  input  logic [17:0] Word_count_I,
  output logic [17:0] SRAM_address_O,
  output logic        SRAM_we_n_O,
  input  logic [15:0] SRAM_read_data_I,
  output logic        UART_TX_O,
  output logic        Busy_O,
  output logic        Done_O,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAT_LAST  = 3'(SRAM_READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_WAIT = 3'd2,
    S_START   = 3'd3,
    S_DATA    = 3'd4,
    S_STOP    = 3'd5,
    S_NEXT    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t      state, state_n;
  logic [17:0] cur_addr, cur_addr_n;
  logic [17:0] remaining, remaining_n;
  logic [15:0] word, word_n;
  logic        byte_sel, byte_sel_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [15:0] baud, baud_n;
  logic [2:0]  lat, lat_n;
  logic [17:0] addr_out_n;
  logic [7:0]  tx_byte_n;
  logic        tx_n;
  logic        busy_n;
  logic        done_n;

  // The SRAM port is only ever read.
  assign SRAM_we_n_O = 1'b1;
  assign dbg_state   = state;

  // State and datapath registers. The outputs are registered from the
  // next-state values, so they line up with the state they belong to.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state          <= S_IDLE;
      cur_addr       <= '0;
      remaining      <= '0;
      word           <= '0;
      byte_sel       <= 1'b0;
      bit_idx        <= '0;
      baud           <= '0;
      lat            <= '0;
      SRAM_address_O <= '0;
      UART_TX_O      <= 1'b1;
      Busy_O         <= 1'b0;
      Done_O         <= 1'b0;
    end else begin
      state          <= state_n;
      cur_addr       <= cur_addr_n;
      remaining      <= remaining_n;
      word           <= word_n;
      byte_sel       <= byte_sel_n;
      bit_idx        <= bit_idx_n;
      baud           <= baud_n;
      lat            <= lat_n;
      SRAM_address_O <= addr_out_n;
      UART_TX_O      <= tx_n;
      Busy_O         <= busy_n;
      Done_O         <= done_n;
    end
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    remaining_n = remaining;
    word_n      = word;
    byte_sel_n  = byte_sel;
    bit_idx_n   = bit_idx;
    baud_n      = baud;
    lat_n       = lat;
    case (state)
      S_IDLE: begin
        if (Start_I) begin
          cur_addr_n  = Base_address_I;
          remaining_n = Word_count_I;
          baud_n      = '0;
          state_n     = (Word_count_I == 18'd0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        // The latency count includes the cycle the address is presented.
        lat_n   = 3'd1;
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat == LAT_LAST) begin
          word_n     = SRAM_read_data_I;
          byte_sel_n = 1'b0;
          baud_n     = '0;
          state_n    = S_START;
        end else begin
          lat_n = lat + 3'd1;
        end
      end
      S_START: begin
        if (baud == BAUD_LAST) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = S_DATA;
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      S_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      S_STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (!byte_sel) begin
            byte_sel_n = 1'b1;
            state_n    = S_START;
          end else begin
            state_n = S_NEXT;
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      S_NEXT: begin
        cur_addr_n  = cur_addr + 18'd1;
        remaining_n = remaining - 18'd1;
        state_n     = (remaining != 18'd1) ? S_RD_ADDR : S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    addr_out_n = (state_n == S_RD_ADDR) ? cur_addr_n : SRAM_address_O;
    tx_byte_n  = byte_sel_n ? word_n[7:0] : word_n[15:8];
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = tx_byte_n[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n = (state_n == S_DONE);
  end

endmodule
